fifo_mp_sr: RTL and testbench

//  Multi-head/multi-tail circular FIFO: up to HEADS pushes and TAILS pops per clock.

---
 rtl/fifo_mp_sr_if.sv | 33 +++
 rtl/fifo_mp_sr.sv | 135 +++++++++++++
 tb/tb_fifo_mp_sr.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_mp_sr_if.sv
// Bus bundle for the multi-head/multi-tail FIFO: producer push side, consumer pop side
// and the status flags. The producer/consumer logic uses the master modport; the FIFO uses the slave modport.
interface fifo_mp_sr_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int HEADS = 2,
  parameter int TAILS = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [HEADS-1:0]            push;
  logic [HEADS-1:0][WIDTH-1:0] dinp;
  logic [HEADS-1:0]            push_ack;
  logic [CW-1:0]               src_num_avail;
  logic                        full;
  logic [TAILS-1:0]            pop;
  logic [TAILS-1:0][WIDTH-1:0] doup;
  logic [TAILS-1:0]            doup_vld;
  logic [CW-1:0]               dst_num_avail;
  logic                        empty;
  logic                        ovf;
  logic                        udf;

  modport master (
    output push, dinp, pop,
    input  push_ack, src_num_avail, full, doup, doup_vld, dst_num_avail, empty, ovf, udf
  );

  modport slave (
    input  push, dinp, pop,
    output push_ack, src_num_avail, full, doup, doup_vld, dst_num_avail, empty, ovf, udf
  );
endinterface

// File: rtl/fifo_mp_sr.sv
// Circular FIFO accepting up to HEADS pushes and serving up to TAILS pops per clock,
// with in-order head arbitration, contiguous-prefix pops and sticky overflow/underflow flags.
module fifo_mp_sr #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int HEADS = 2,
  parameter int TAILS = 2
) (
  input  logic         clk,
  input  logic         rst,
  fifo_mp_sr_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_mp_sr: DEPTH must be a power of 2 and >= 2");
  end
  if (HEADS < 1 || HEADS > DEPTH) begin : g_bad_heads
    $error("fifo_mp_sr: HEADS must be in 1..DEPTH");
  end
  if (TAILS < 1 || TAILS > DEPTH) begin : g_bad_tails
    $error("fifo_mp_sr: TAILS must be in 1..DEPTH");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [CW-1:0]               free_cnt;
  logic [CW-1:0]               p_cnt;
  logic [CW-1:0]               q_cnt;
  logic [HEADS-1:0]            ack;
  logic [AW-1:0]               wslot [HEADS];
  logic [AW-1:0]               rslot [TAILS];
  logic [TAILS-1:0]            vld;
  logic [TAILS-1:0][WIDTH-1:0] doup;
  logic                        ovf_set;
  logic                        udf_set;
  logic                        pop_run;

  // Push arbitration: free space is the start-of-cycle count, so a pop never
  // makes room for a push in the same cycle. Reset suppresses every ack.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    free_cnt = CW'(DEPTH) - occ_q;
    p_cnt    = '0;
    ack      = '0;
    ovf_set  = 1'b0;
    for (int i = 0; i < HEADS; i++) begin
      // NOTE: blocking assignments here let p_cnt accumulate in head order within one evaluation.
      wslot[i] = wptr_q + p_cnt[AW-1:0];
      if (bus.push[i]) begin
        if (!rst && p_cnt < free_cnt) begin
          ack[i] = 1'b1;
          p_cnt  = p_cnt + CW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
    end
  end

  // Presentation and pop count: only the unbroken run of requests from tail 0 pops.
  always_comb begin
    q_cnt   = '0;
    udf_set = 1'b0;
    pop_run = 1'b1;
    vld     = '0;
    doup    = '0;
    for (int i = 0; i < TAILS; i++) begin
      rslot[i] = rptr_q + AW'(i);
      vld[i]   = CW'(i) < occ_q;
      doup[i]  = vld[i] ? mem_q[rslot[i]] : '0;
      if (bus.pop[i] && !vld[i]) begin
        udf_set = 1'b1;
      end
      if (pop_run && bus.pop[i] && vld[i]) begin
        q_cnt = q_cnt + CW'(1);
      end else begin
        pop_run = 1'b0;
      end
    end
  end

  always_comb begin
    occ_d  = occ_q + p_cnt - q_cnt;
    wptr_d = wptr_q + p_cnt[AW-1:0];
    rptr_d = rptr_q + q_cnt[AW-1:0];
    ovf_d  = ovf_q | ovf_set;
    udf_d  = udf_q | udf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      // NOTE: storage is cleared on reset so the contents are defined; drop this loop if a RAM macro is used.
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      for (int i = 0; i < HEADS; i++) begin
        if (ack[i]) begin
          mem_q[wslot[i]] <= bus.dinp[i];
        end
      end
    end
  end

  assign bus.push_ack      = ack;
  assign bus.doup          = doup;
  assign bus.doup_vld      = vld;
  assign bus.src_num_avail = CW'(DEPTH) - occ_q;
  assign bus.dst_num_avail = occ_q;
  assign bus.full          = (occ_q == CW'(DEPTH));
  assign bus.empty         = (occ_q == '0);
  assign bus.ovf           = ovf_q;
  assign bus.udf           = udf_q;

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ_q <= CW'(DEPTH))
    else $error("fifo_mp_sr: occupancy exceeded DEPTH");

endmodule

// File: tb/tb_fifo_mp_sr.sv
// Directed bench for fifo_mp_sr: accepted push data goes into a scoreboard queue and a
// negedge monitor compares every popped tail against it; status is checked per scenario.
module tb_fifo_mp_sr;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int HEADS = 2;
  localparam int TAILS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_mp_sr_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HEADS(HEADS), .TAILS(TAILS)) bus ();

  fifo_mp_sr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HEADS(HEADS), .TAILS(TAILS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q [$];
  logic             mon_run;
  logic [WIDTH-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each tail in the popped contiguous run must present the oldest expected entry.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      mon_run = 1'b1;
      for (int i = 0; i < TAILS; i++) begin
        if (mon_run && bus.pop[i] && bus.doup_vld[i]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underrun: got data %0h on tail %0d, expected no entry", bus.doup[i], i);
          end else begin
            mon_exp = exp_q.pop_front();
            check("sb_data", bus.doup[i], mon_exp);
          end
        end else begin
          mon_run = 1'b0;
        end
      end
    end
  end

  // One clock of stimulus; acks are checked mid-cycle and acked data is queued as expected output.
  task automatic cycle(input logic [1:0] push, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] pop, input logic [1:0] exp_ack, input string tag);
    bus.push    = push;
    bus.dinp[0] = d0;
    bus.dinp[1] = d1;
    bus.pop     = pop;
    @(negedge clk);
    check({tag, "_ack"}, bus.push_ack, exp_ack);
    if (exp_ack[0]) exp_q.push_back(d0);
    if (exp_ack[1]) exp_q.push_back(d1);
    @(posedge clk);
    #1;
    bus.push = '0;
    bus.pop  = '0;
  endtask

  task automatic status(input string tag, input int dst, input logic [1:0] vld,
                        input logic ovf, input logic udf);
    @(negedge clk);
    check({tag, "_dst"},   bus.dst_num_avail, dst);
    check({tag, "_src"},   bus.src_num_avail, DEPTH - dst);
    check({tag, "_empty"}, bus.empty, dst == 0);
    check({tag, "_full"},  bus.full, dst == DEPTH);
    check({tag, "_vld"},   bus.doup_vld, vld);
    check({tag, "_ovf"},   bus.ovf, ovf);
    check({tag, "_udf"},   bus.udf, udf);
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [31:0] base, input string tag);
    for (int k = 0; k < n / 2; k++) cycle(2'b11, base + 2 * k, base + 2 * k + 1, 2'b00, 2'b11, tag);
    if (n % 2 == 1) cycle(2'b01, base + n - 1, 32'h0, 2'b00, 2'b01, tag);
  endtask

  task automatic drain(input int n, input string tag);
    for (int k = 0; k < n / 2; k++) cycle(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, tag);
    if (n % 2 == 1) cycle(2'b00, 32'h0, 32'h0, 2'b01, 2'b00, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.push    = 2'b11;
    bus.dinp[0] = 32'hDEAD_0000;
    bus.dinp[1] = 32'hDEAD_0001;
    bus.pop     = 2'b00;

    // T1: reset held two cycles with pushes asserted.
    repeat (2) begin
      @(negedge clk);
      check("t1_rst_ack", bus.push_ack, 2'b00);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.push = '0;
    @(negedge clk);
    check("t1_doup", bus.doup, 64'h0);
    @(posedge clk);
    #1;
    status("t1", 0, 2'b00, 1'b0, 1'b0);

    // T2: dual push then dual pop.
    cycle(2'b11, 32'hAAAA_000A, 32'hBBBB_000B, 2'b00, 2'b11, "t2_push");
    @(negedge clk);
    check("t2_doup0", bus.doup[0], 32'hAAAA_000A);
    check("t2_doup1", bus.doup[1], 32'hBBBB_000B);
    check("t2_vld",   bus.doup_vld, 2'b11);
    check("t2_dst",   bus.dst_num_avail, 2);
    @(posedge clk);
    #1;
    cycle(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, "t2_pop");
    status("t2_after_pop", 0, 2'b00, 1'b0, 1'b0);

    // T3: fill to 15, then a dual push only gets head 0 in.
    fill(15, 32'h1000_0000, "t3_fill");
    status("t3_15", 15, 2'b11, 1'b0, 1'b0);
    cycle(2'b11, 32'hCCCC_000C, 32'hDDDD_000D, 2'b00, 2'b01, "t3_ovf");
    status("t3_full", 16, 2'b11, 1'b1, 1'b0);

    // T4: full FIFO with a pop still refuses the push.
    cycle(2'b01, 32'hEEEE_000E, 32'h0, 2'b01, 2'b00, "t4");
    status("t4_after", 15, 2'b11, 1'b1, 1'b0);
    drain(15, "t4_drain");
    status("t4_empty", 0, 2'b00, 1'b1, 1'b0);

    // Move both pointers from 2 to 15.
    fill(13, 32'h2000_0000, "pre5_fill");
    drain(13, "pre5_drain");

    // T5: two-entry push and pop straddling index 15 -> 0.
    cycle(2'b11, 32'h5555_000A, 32'h5555_000B, 2'b00, 2'b11, "t5_push");
    @(negedge clk);
    check("t5_doup0", bus.doup[0], 32'h5555_000A);
    check("t5_doup1", bus.doup[1], 32'h5555_000B);
    @(posedge clk);
    #1;
    cycle(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, "t5_pop");
    status("t5_empty", 0, 2'b00, 1'b1, 1'b0);
    cycle(2'b01, 32'h6666_0001, 32'h0, 2'b00, 2'b01, "t5_rptr");
    @(negedge clk);
    check("t5_z_doup0", bus.doup[0], 32'h6666_0001);
    check("t5_z_doup1", bus.doup[1], 32'h0);
    check("t5_z_vld",   bus.doup_vld, 2'b01);
    @(posedge clk);
    #1;

    // T6a: occupancy 1 with both tails popping.
    cycle(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, "t6a");
    status("t6a_after", 0, 2'b00, 1'b1, 1'b1);

    // Reset clears the sticky flags and the scoreboard.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    status("t6_rst", 0, 2'b00, 1'b0, 1'b0);

    // T6b: a pop on tail 1 alone is ignored.
    cycle(2'b11, 32'h7777_0001, 32'h7777_0002, 2'b00, 2'b11, "t6b_push");
    cycle(2'b00, 32'h0, 32'h0, 2'b10, 2'b00, "t6b_pop");
    status("t6b_after", 2, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    check("t6b_doup0", bus.doup[0], 32'h7777_0001);
    @(posedge clk);
    #1;
    cycle(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, "t6b_drain");
    status("t6b_empty", 0, 2'b00, 1'b0, 1'b0);

    check("sb_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
